// File: rtl/divider_arbiter.sv
// Round-robin arbiter that time-shares one divider among NUM_REQ channels.
// One operation in flight: IDLE (grant) -> WAIT (divider settling) -> RESP (hold result).
module divider_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 16,
    parameter int DIV_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_entry_1,
    input  logic [NUM_REQ*DATA_W-1:0] req_entry_2,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         div_entry_1,
    output logic [DATA_W-1:0]         div_entry_2,
    input  logic [DATA_W-1:0]         div_output_1,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_dbz,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic                      busy,
    output logic [1:0]                dbg_state,
    output logic [2:0]                dbg_rr_ptr
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and rsp_valid holds until consumed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant;
    logic [3:0]         wait_cnt;
    logic               arb_found;
    logic [PTR_W-1:0]   arb_win;
    logic [PTR_W:0]     arb_sum;
    logic [DATA_W-1:0]  win_entry_1;
    logic [DATA_W-1:0]  win_entry_2;
    logic               grant_fire;
    logic               win_dbz;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            arb_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (arb_sum >= (PTR_W+1)'(NUM_REQ)) begin
                arb_sum = arb_sum - (PTR_W+1)'(NUM_REQ);
            end
            if (req_valid[arb_sum[PTR_W-1:0]]) begin
                arb_found = 1'b1;
                arb_win   = arb_sum[PTR_W-1:0];
            end
        end
    end

    assign win_entry_1 = req_entry_1[int'(arb_win)*DATA_W +: DATA_W];
    assign win_entry_2 = req_entry_2[int'(arb_win)*DATA_W +: DATA_W];
    assign win_dbz     = (win_entry_2 == '0);
    assign grant_fire  = (state == IDLE) && arb_found && reset_n;

    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        case (state)
            IDLE: begin
                if (grant_fire) begin
                    req_ready[arb_win] = 1'b1;
                    state_next         = win_dbz ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd1) state_next = RESP;
            end
            RESP: begin
                rsp_valid[grant] = 1'b1;
                if (rsp_ready[grant]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            wait_cnt    <= '0;
            div_entry_1 <= '0;
            div_entry_2 <= '0;
            rsp_data    <= '0;
            rsp_dbz     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        grant       <= arb_win;
                        div_entry_1 <= win_entry_1;
                        div_entry_2 <= win_entry_2;
                        rr_ptr      <= (arb_win == PTR_W'(NUM_REQ - 1)) ? '0 : arb_win + 1'b1;
                        if (win_dbz) begin
                            rsp_data <= '1;
                            rsp_dbz  <= 1'b1;
                        end else begin
                            wait_cnt <= 4'(DIV_LATENCY);
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        rsp_data <= div_output_1;
                        rsp_dbz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign dbg_state  = state;
    assign dbg_rr_ptr = 3'(rr_ptr);

endmodule
